// File: rtl/xor_stream_cipher.sv
// xor_stream_cipher: XORs a stream of data beats with either a static key or a
// Galois-LFSR keystream. One registered output stage with a valid/ready
// handshake sustains one beat per cycle. The block stays unkeyed until the
// first key_load after reset.
module xor_stream_cipher #(
  parameter int                DATA_W = 8,
  parameter int                LFSR_W = 16,
  parameter logic [LFSR_W-1:0] POLY   = 16'hB400,
  parameter int                CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_load,
  input  logic [LFSR_W-1:0] key_in,
  input  logic              mode_in,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              keyed,
  output logic [CNT_W-1:0]  beat_cnt
);

  if (LFSR_W < DATA_W) begin : g_width_check
    $error("xor_stream_cipher: LFSR_W must be >= DATA_W");
  end

  typedef enum logic {UNKEYED = 1'b0, KEYED = 1'b1} state_t;

  state_t              state_q;
  state_t              state_d;
  logic [LFSR_W-1:0]   lfsr_q;
  logic                mode_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                vld_p1;
  logic [DATA_W-1:0]   data_p1;
  logic                accept;
  logic [DATA_W-1:0]   ks;

  // One Galois shift: shift right, fold the feedback mask in when a one drops out.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return (s >> 1) ^ (s[0] ? POLY : '0);
  endfunction

  // An all-zero seed would freeze the LFSR, so it is replaced by 1.
  function automatic logic [LFSR_W-1:0] seed_fix(input logic [LFSR_W-1:0] k);
    return (k == '0) ? {{(LFSR_W-1){1'b0}}, 1'b1} : k;
  endfunction

  // State register: only reset leaves KEYED.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= UNKEYED;
    else        state_q <= state_d;
  end

  // Next-state: any key_load makes the block keyed.
  always_comb begin
    state_d = state_q;
    if (key_load) state_d = KEYED;
  end

  // Outputs decoded from state plus the handshake; a key_load cycle never accepts.
  always_comb begin
    keyed    = (state_q == KEYED);
    in_ready = (state_q == KEYED) && !key_load && (!vld_p1 || out_ready);
  end

  assign accept    = in_valid && in_ready;
  assign ks        = lfsr_q[DATA_W-1:0];
  assign out_valid = vld_p1;
  assign out_data  = data_p1;
  assign beat_cnt  = cnt_q;

  // Key/keystream register: loaded by key_load, advanced once per accepted beat in mode 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= '0;
      mode_q <= 1'b0;
    end else if (key_load) begin
      lfsr_q <= seed_fix(key_in);
      mode_q <= mode_in;
    end else if (accept && mode_q) begin
      lfsr_q <= lfsr_step(lfsr_q);
    end
  end

  // Beat counter: cleared by key_load, free-running wrap otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        cnt_q <= '0;
    else if (key_load) cnt_q <= '0;
    else if (accept)   cnt_q <= cnt_q + CNT_W'(1);
  end

  // ---- stage p1: output register, filled on accept and emptied on drain ----
  // Output stage: a new beat overwrites on accept; otherwise a drained beat clears valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end else if (accept) begin
      vld_p1  <= 1'b1;
      data_p1 <= in_data ^ ks;
    end else if (out_ready) begin
      vld_p1  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_xor_stream_cipher.sv
// tb_xor_stream_cipher: directed and randomized stimulus for xor_stream_cipher,
// checked cycle by cycle against a transaction-level reference model.
module tb_xor_stream_cipher;

  localparam int DATA_W = 8;
  localparam int LFSR_W = 16;
  localparam logic [LFSR_W-1:0] POLY = 16'hB400;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              key_load;
  logic [LFSR_W-1:0] key_in;
  logic              mode_in;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic              keyed;
  logic [CNT_W-1:0]  beat_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit                m_keyed;
  bit                m_mode;
  bit [LFSR_W-1:0]   m_lfsr;
  int                m_cnt;
  bit                m_ov;
  bit [DATA_W-1:0]   m_od;
  logic [DATA_W-1:0] got[$];

  xor_stream_cipher #(
    .DATA_W(DATA_W), .LFSR_W(LFSR_W), .POLY(POLY), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_load(key_load), .key_in(key_in),
    .mode_in(mode_in), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .keyed(keyed), .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  function automatic bit [LFSR_W-1:0] ks_advance(input bit [LFSR_W-1:0] s);
    return (s >> 1) ^ (s[0] ? POLY : 16'h0000);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_keyed = 0; m_mode = 0; m_lfsr = '0; m_cnt = 0; m_ov = 0; m_od = '0;
  endtask

  // One clock cycle: compare at the falling edge, advance the model at the rising edge.
  task automatic tick();
    bit exp_rdy, acc;
    @(negedge clk);
    exp_rdy = m_keyed && !key_load && (!m_ov || out_ready);
    chk("in_ready", in_ready, exp_rdy);
    chk("out_valid", out_valid, m_ov);
    chk("keyed", keyed, m_keyed);
    chk("beat_cnt", beat_cnt, m_cnt);
    if (m_ov) chk("out_data", out_data, m_od);
    if (out_valid && out_ready) got.push_back(out_data);
    acc = exp_rdy && in_valid;
    @(posedge clk);
    if (acc) begin
      m_ov = 1;
      m_od = in_data ^ m_lfsr[DATA_W-1:0];
      if (m_mode) m_lfsr = ks_advance(m_lfsr);
      m_cnt = (m_cnt + 1) % (1 << CNT_W);
    end else if (out_ready) begin
      m_ov = 0;
    end
    if (key_load) begin
      m_lfsr  = (key_in == 0) ? 16'h0001 : key_in;
      m_mode  = mode_in;
      m_cnt   = 0;
      m_keyed = 1;
    end
    #1;
  endtask

  task automatic load_key(input logic [LFSR_W-1:0] k, input logic m);
    key_load = 1; key_in = k; mode_in = m;
    tick();
    key_load = 0;
  endtask

  task automatic random_traffic(input int n, input bit with_keys);
    for (int i = 0; i < n; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = DATA_W'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      key_load  = with_keys && ($urandom_range(0, 15) == 0);
      key_in    = ($urandom_range(0, 7) == 0) ? 16'h0000 : LFSR_W'($urandom);
      mode_in   = 1'($urandom);
      tick();
    end
    key_load = 0;
  endtask

  initial begin
    rst_n = 0; key_load = 0; key_in = '0; mode_in = 0;
    in_valid = 0; in_data = '0; out_ready = 0;
    model_reset();
    #12;
    chk("rst_keyed", keyed, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_beat_cnt", beat_cnt, 0);
    @(posedge clk); #1;
    rst_n = 1;

    // Unkeyed: beats offered but never accepted
    out_ready = 1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1; in_data = DATA_W'($urandom);
      tick();
    end

    // Static key 0x00BE; key_load arrives while a beat is offered
    in_valid = 1; in_data = 8'h5A;
    @(negedge clk);
    key_load = 1; key_in = 16'h00BE; mode_in = 0;
    #1 chk("load_unkeyed_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    m_lfsr = 16'h00BE; m_mode = 0; m_cnt = 0; m_keyed = 1;
    key_load = 0;
    chk("load_no_accept", out_valid, 1'b0);
    got.delete();
    in_data = 8'h00; tick();
    in_data = 8'hFF; tick();
    in_valid = 0; tick(); tick();
    chk("static_count", got.size(), 2);
    if (got.size() == 2) begin
      chk("static_beat0", got[0], 8'hBE);
      chk("static_beat1", got[1], 8'h41);
    end

    random_traffic(40, 1'b0);

    // LFSR keystream, back-to-back
    out_ready = 1; in_valid = 0; tick();
    load_key(16'hACE1, 1'b1);
    got.delete();
    in_valid = 1; in_data = 8'h00;
    tick(); tick(); tick();
    in_valid = 0; tick(); tick();
    chk("lfsr_cnt3", beat_cnt, 3);
    chk("lfsr_count", got.size(), 3);
    if (got.size() == 3) begin
      chk("lfsr_beat0", got[0], 8'hE1);
      chk("lfsr_beat1", got[1], 8'h70);
      chk("lfsr_beat2", got[2], 8'h38);
    end

    // Same stream with a 4-cycle downstream stall
    load_key(16'hACE1, 1'b1);
    got.delete();
    in_valid = 1; in_data = 8'h00; out_ready = 1;
    tick(); tick();
    out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_in_ready", in_ready, 1'b0);
      chk("stall_hold", out_data, 8'h70);
    end
    out_ready = 1;
    tick();
    in_valid = 0; tick(); tick();
    chk("stall_count", got.size(), 3);
    if (got.size() == 3) begin
      chk("stall_beat0", got[0], 8'hE1);
      chk("stall_beat1", got[1], 8'h70);
      chk("stall_beat2", got[2], 8'h38);
    end

    // Zero key: replaced by seed 1
    load_key(16'h0000, 1'b1);
    got.delete();
    in_valid = 1; in_data = 8'h00;
    tick(); tick();
    in_valid = 0; tick(); tick();
    chk("zero_count", got.size(), 2);
    if (got.size() == 2) begin
      chk("zero_beat0", got[0], 8'h01);
      chk("zero_beat1", got[1], 8'h00);
    end

    // Counter wrap: 17 beats on a 4-bit counter lands on 1
    load_key(16'h1234, 1'b0);
    in_valid = 1; in_data = 8'h11;
    for (int i = 0; i < 17; i++) tick();
    in_valid = 0; tick();
    chk("cnt_wrap", beat_cnt, 1);

    // Random traffic with re-keys arriving over pending beats
    random_traffic(300, 1'b1);

    // Asynchronous reset with a beat pending
    load_key(16'hACE1, 1'b1);
    in_valid = 1; in_data = 8'h3C; out_ready = 0;
    tick(); tick();
    chk("pre_rst_valid", out_valid, 1'b1);
    #3 rst_n = 0;
    #1;
    chk("async_out_valid", out_valid, 1'b0);
    chk("async_keyed", keyed, 1'b0);
    chk("async_in_ready", in_ready, 1'b0);
    chk("async_beat_cnt", beat_cnt, 0);
    chk("async_out_data", out_data, 8'h00);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1; out_ready = 1;
    tick(); tick();
    load_key(16'hACE1, 1'b1);
    got.delete();
    in_data = 8'h00; tick();
    in_valid = 0; tick(); tick();
    chk("rekey_count", got.size(), 1);
    if (got.size() == 1) chk("rekey_beat0", got[0], 8'hE1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
